// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared RV32 constants for the fetch and decode stages.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int          ILEN     = 32;
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

`default_nettype wire

// File: rtl/busca_instrucao.sv
// ============================================================================
// Module : busca_instrucao
// Brief  : Instruction fetch stage: PC, instruction register, branch redirect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module busca_instrucao
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] ads,
    input  logic [ILEN-1:0]   ins_in,
    output logic [ILEN-1:0]   ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              halt,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [11:0]       br_off
);

    localparam int EXT_W = ADDR_W + 12;

    logic [ADDR_W-1:0] r_pc;
    logic [ILEN-1:0]   r_ir;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_ir_valid;

    logic              w_load;
    logic              w_consume;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_next;

    assign w_load    = (!r_ir_valid || ir_ready) && !halt && !br_taken;
    assign w_consume = r_ir_valid && ir_ready;

    // Sign-extend the offset, add, then keep only the low ADDR_W bits (wraps).
    assign w_target = ADDR_W'(EXT_W'(br_pc) + {{ADDR_W{br_off[11]}}, br_off});

    always_comb begin
        w_pc_next = r_pc;
        if (!reset) begin
            w_pc_next = RESET_PC;
        end else if (br_taken) begin
            w_pc_next = w_target;
        end else if (w_load) begin
            w_pc_next = r_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        r_pc <= w_pc_next;
        if (!reset) begin
            r_ir       <= NOP_INSN;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
        end else if (br_taken) begin
            r_ir_valid <= 1'b0;
        end else if (w_load) begin
            r_ir       <= ins_in;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
        end else if (w_consume) begin
            r_ir_valid <= 1'b0;
        end
    end

    assign ads      = r_pc;
    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;

endmodule

`default_nettype wire

// File: tb/tb_busca_instrucao.sv
// ============================================================================
// Module : tb_busca_instrucao
// Brief  : Directed self-checking bench for busca_instrucao with a reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_busca_instrucao;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam logic [31:0] NOP = 32'h00000013;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] ads;
    logic [31:0]       ins_in;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              halt;
    logic              br_taken;
    logic [ADDR_W-1:0] br_pc;
    logic [11:0]       br_off;

    logic [31:0] mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    int          m_pc;
    logic [31:0] m_ir;
    int          m_irpc;
    logic        m_valid;
    bit          m_live = 0;
    bit          cmp_on = 0;

    busca_instrucao #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
        .clk      (clk),
        .reset    (reset),
        .ads      (ads),
        .ins_in   (ins_in),
        .ir       (ir),
        .ir_pc    (ir_pc),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .halt     (halt),
        .br_taken (br_taken),
        .br_pc    (br_pc),
        .br_off   (br_off)
    );

    always #5 clk = ~clk;

    assign ins_in = mem[ads];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the stage's rules restated with integer arithmetic on the PC.
    always @(posedge clk) begin
        bit accepted;
        int tgt;
        if (!reset) begin
            m_pc    = 0;
            m_ir    = NOP;
            m_irpc  = 0;
            m_valid = 1'b0;
            m_live  = 1;
        end else if (m_live) begin
            accepted = m_valid && ir_ready;
            if (br_taken) begin
                tgt     = int'(br_pc) + int'($signed(br_off));
                m_pc    = ((tgt % DEPTH) + DEPTH) % DEPTH;
                m_valid = 1'b0;
            end else if (!halt && (!m_valid || accepted)) begin
                m_ir    = mem[m_pc];
                m_irpc  = m_pc;
                m_valid = 1'b1;
                m_pc    = (m_pc + 1) % DEPTH;
            end else if (accepted) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on && m_live) begin
            chk("model_ads",      32'(ads),      32'(m_pc));
            chk("model_ir",       ir,            m_ir);
            chk("model_ir_pc",    32'(ir_pc),    32'(m_irpc));
            chk("model_ir_valid", 32'(ir_valid), 32'(m_valid));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_state(input string tag, input int e_ads, input int e_pc, input logic e_v);
        chk({tag, "_ads"},   32'(ads),      32'(e_ads));
        chk({tag, "_ir_pc"}, 32'(ir_pc),    32'(e_pc));
        chk({tag, "_valid"}, 32'(ir_valid), 32'(e_v));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 + 32'(i) * 32'h0000_0101;
        mem[0] = NOP;
        mem[1] = 32'h00302383;
        mem[2] = NOP;

        reset = 1'b0; ir_ready = 1'b1; halt = 1'b0;
        br_taken = 1'b0; br_pc = '0; br_off = '0;

        // reset held for two cycles
        tick();
        cmp_on = 1;
        chk("rst1_ir", ir, NOP);
        expect_state("rst1", 0, 0, 1'b0);
        tick();
        chk("rst2_ir", ir, NOP);
        expect_state("rst2", 0, 0, 1'b0);

        reset = 1'b1;
        tick();
        chk("seq0_ir", ir, 32'h00000013);
        expect_state("seq0", 1, 0, 1'b1);
        tick();
        chk("seq1_ir", ir, 32'h00302383);
        expect_state("seq1", 2, 1, 1'b1);
        tick();
        expect_state("seq2", 3, 2, 1'b1);
        tick();
        expect_state("seq3", 4, 3, 1'b1);
        tick();
        expect_state("seq4", 5, 4, 1'b1);

        // backpressure for three cycles
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ir", ir, mem[4]);
            expect_state("bp", 5, 4, 1'b1);
        end
        ir_ready = 1'b1;
        tick();
        expect_state("bp_rel", 6, 5, 1'b1);

        // forward redirect
        br_taken = 1'b1; br_pc = 6'd0; br_off = 12'd2;
        tick();
        expect_state("fwd_n1", 2, 5, 1'b0);
        br_taken = 1'b0;
        tick();
        chk("fwd_n2_ir", ir, mem[2]);
        expect_state("fwd_n2", 3, 2, 1'b1);

        // backward redirect with wrap, then sequential wrap 63 -> 0
        br_taken = 1'b1; br_pc = 6'd3; br_off = 12'hFFB;
        tick();
        expect_state("bwd_n1", 62, 2, 1'b0);
        br_taken = 1'b0;
        tick();
        expect_state("bwd_n2", 63, 62, 1'b1);
        tick();
        expect_state("wrap63", 0, 63, 1'b1);
        tick();
        expect_state("wrap0", 1, 0, 1'b1);

        // halt consumes without loading, redirect still wins over halt
        halt = 1'b1;
        tick();
        expect_state("halt1", 1, 0, 1'b0);
        tick();
        expect_state("halt2", 1, 0, 1'b0);
        br_taken = 1'b1; br_pc = 6'd10; br_off = 12'd5;
        tick();
        expect_state("halt_br", 15, 0, 1'b0);
        br_taken = 1'b0;
        tick();
        expect_state("halt_hold", 15, 0, 1'b0);
        halt = 1'b0;
        tick();
        chk("resume_ir", ir, mem[15]);
        expect_state("resume", 16, 15, 1'b1);

        // reset together with redirect and transfer
        br_taken = 1'b1; br_pc = 6'd20; br_off = 12'd1; reset = 1'b0;
        tick();
        chk("midrst_ir", ir, NOP);
        expect_state("midrst", 0, 0, 1'b0);
        br_taken = 1'b0; reset = 1'b1;
        tick();
        expect_state("post_rst", 1, 0, 1'b1);

        // mixed ready/halt pattern, checked by the model only
        for (int k = 0; k < 12; k++) begin
            ir_ready = k[0] ^ k[2];
            halt     = (k == 5);
            tick();
        end

        cmp_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL timeout: simulation did not complete, limit %0d", 20000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
